// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl
//   Address and occupancy controller for a downward-growing hardware stack
//   occupying the RAM window [LIMIT..BASE]. Produces the RAM address for
//   push / pop / replace-top operations, tracks occupancy, full/empty state,
//   sticky overflow/underflow errors and a high-water mark.
//
//   The stack RAM write enable is not generated here. The control unit must
//   gate the RAM write with ~o_full so a rejected push never corrupts memory.
//
//   Optional feature macro: STACK_CTRL_LOAD_EN
//     Adds i_sp_load / i_sp_din so software can restore a saved stack pointer
//     on a context switch. Without the macro, sp changes only through
//     push, pop or rst.
// -----------------------------------------------------------------------------
module stack_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE       = 2**ADDR_WIDTH - 1,
    parameter int LIMIT      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_err_clr,
`ifdef STACK_CTRL_LOAD_EN
    input  logic                  i_sp_load,
    input  logic [ADDR_WIDTH-1:0] i_sp_din,
`endif
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_ovf_err,
    output logic                  o_udf_err,
    output logic [ADDR_WIDTH:0]   o_hwm
);

    localparam int                    DEPTH   = BASE - LIMIT + 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE);

    // State: sp points at the next free slot; level is tracked independently
    // because with a full-size window sp alone cannot tell empty from full.
    logic [ADDR_WIDTH-1:0] r_sp;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_ovf_err;
    logic                  r_udf_err;
    logic [ADDR_WIDTH:0]   r_hwm;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push_path;
    logic                  w_pop_only;
    logic [ADDR_WIDTH-1:0] w_sp_nxt;
    logic [ADDR_WIDTH:0]   w_level_nxt;
    logic                  w_ovf_set;
    logic                  w_udf_set;
    logic [ADDR_WIDTH:0]   w_hwm_base;
    logic [ADDR_WIDTH:0]   w_hwm_nxt;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == DEPTH_L);

    // A push together with a pop on an empty stack has no top to replace,
    // so it behaves exactly like a plain push.
    assign w_push_path = i_push & (~i_pop | w_empty);
    assign w_pop_only  = i_pop & ~i_push;

`ifdef STACK_CTRL_LOAD_EN
    logic [ADDR_WIDTH:0] w_load_level;
    logic                w_load_ok;

    // Occupancy implied by a restored sp; out-of-window values wrap to a
    // level beyond DEPTH and are rejected.
    assign w_load_level = {1'b0, BASE_A} - {1'b0, i_sp_din};
    assign w_load_ok    = (i_sp_din <= BASE_A) && (w_load_level <= DEPTH_L);
`endif

    // Push writes the free slot at sp; everything else addresses the top
    // entry at sp+1 (pop, replace-top, idle peek).
    assign o_addr = w_push_path ? r_sp : r_sp + ADDR_WIDTH'(1);

    // Next-state decode for sp, level and error set requests.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_sp_nxt    = r_sp;
        w_level_nxt = r_level;
        w_ovf_set   = 1'b0;
        w_udf_set   = 1'b0;
`ifdef STACK_CTRL_LOAD_EN
        if (i_sp_load) begin
            if (w_load_ok) begin
                w_sp_nxt    = i_sp_din;
                w_level_nxt = w_load_level;
            end else begin
                w_ovf_set = 1'b1;
            end
        end else begin
`else
        begin
`endif
            if (w_push_path) begin
                if (!w_full) begin
                    w_sp_nxt    = r_sp - ADDR_WIDTH'(1);
                    w_level_nxt = r_level + (ADDR_WIDTH+1)'(1);
                end else begin
                    w_ovf_set = 1'b1;
                end
            end else if (w_pop_only) begin
                if (!w_empty) begin
                    w_sp_nxt    = r_sp + ADDR_WIDTH'(1);
                    w_level_nxt = r_level - (ADDR_WIDTH+1)'(1);
                end else begin
                    w_udf_set = 1'b1;
                end
            end
            // push & pop on a non-empty stack: replace top, nothing moves.
        end
    end

    // High-water mark follows the next level; err_clr restarts it from the
    // level being entered this cycle rather than from zero.
    assign w_hwm_base = i_err_clr ? '0 : r_hwm;
    assign w_hwm_nxt  = (w_level_nxt > w_hwm_base) ? w_level_nxt : w_hwm_base;

    // State registers; a new error in the same cycle as err_clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp      <= BASE_A;
            r_level   <= '0;
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
            r_hwm     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            r_sp      <= w_sp_nxt;
            r_level   <= w_level_nxt;
            r_ovf_err <= w_ovf_set | (r_ovf_err & ~i_err_clr);
            r_udf_err <= w_udf_set | (r_udf_err & ~i_err_clr);
            r_hwm     <= w_hwm_nxt;
        end
    end

    assign o_level   = r_level;
    assign o_empty   = w_empty;
    assign o_full    = w_full;
    assign o_ovf_err = r_ovf_err;
    assign o_udf_err = r_udf_err;
    assign o_hwm     = r_hwm;

endmodule

// File: tb/tb_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_ctrl
//   Self-checking bench for stack_ctrl with ADDR_WIDTH=8, BASE=255, LIMIT=248
//   (DEPTH=8). A vector table drives push/pop/err_clr; the combinational
//   address is checked in the same cycle and the expected registered state is
//   queued, then popped and compared after the clock edge. Hand-written
//   sequences cover asynchronous reset mid-push and, when built with
//   STACK_CTRL_LOAD_EN, the sp load port.
// -----------------------------------------------------------------------------
module tb_stack_ctrl;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic       err_clr;
    logic [7:0] addr;
    logic [8:0] level;
    logic       empty;
    logic       full;
    logic       ovf_err;
    logic       udf_err;
    logic [8:0] hwm;
`ifdef STACK_CTRL_LOAD_EN
    logic       sp_load;
    logic [7:0] sp_din;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [8:0] level;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       udf;
        logic [8:0] hwm;
    } st_t;

    typedef struct {
        logic       push;
        logic       pop;
        logic       clr;
        logic [7:0] addr;
        st_t        st;
    } vec_t;

    st_t  sb[$];
    vec_t vecs[29];

    stack_ctrl #(
        .ADDR_WIDTH (8),
        .BASE       (255),
        .LIMIT      (248)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_push    (push),
        .i_pop     (pop),
        .i_err_clr (err_clr),
`ifdef STACK_CTRL_LOAD_EN
        .i_sp_load (sp_load),
        .i_sp_din  (sp_din),
`endif
        .o_addr    (addr),
        .o_level   (level),
        .o_empty   (empty),
        .o_full    (full),
        .o_ovf_err (ovf_err),
        .o_udf_err (udf_err),
        .o_hwm     (hwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_state(input string tag, input st_t e);
        check({tag, " level"}, int'(level),   int'(e.level));
        check({tag, " empty"}, int'(empty),   int'(e.empty));
        check({tag, " full"},  int'(full),    int'(e.full));
        check({tag, " ovf"},   int'(ovf_err), int'(e.ovf));
        check({tag, " udf"},   int'(udf_err), int'(e.udf));
        check({tag, " hwm"},   int'(hwm),     int'(e.hwm));
    endtask

    function automatic vec_t mk(input logic p, input logic q, input logic c,
                                input int a, input int lv, input logic ov,
                                input logic ud, input int hw);
        vec_t v;
        v.push     = p;
        v.pop      = q;
        v.clr      = c;
        v.addr     = 8'(a);
        v.st.level = 9'(lv);
        v.st.empty = (lv == 0);
        v.st.full  = (lv == 8);
        v.st.ovf   = ov;
        v.st.udf   = ud;
        v.st.hwm   = 9'(hw);
        return v;
    endfunction

    initial begin
        st_t  e;
        st_t  got_exp;
        // push, pop, clr, addr, level-after, ovf, udf, hwm
        vecs[0]  = mk(0, 0, 0,   0, 0, 0, 0, 0);   // idle peek wraps to 0x00
        vecs[1]  = mk(1, 0, 0, 255, 1, 0, 0, 1);
        vecs[2]  = mk(1, 0, 0, 254, 2, 0, 0, 2);
        vecs[3]  = mk(1, 0, 0, 253, 3, 0, 0, 3);
        vecs[4]  = mk(1, 0, 0, 252, 4, 0, 0, 4);
        vecs[5]  = mk(1, 0, 0, 251, 5, 0, 0, 5);
        vecs[6]  = mk(1, 0, 0, 250, 6, 0, 0, 6);
        vecs[7]  = mk(1, 0, 0, 249, 7, 0, 0, 7);
        vecs[8]  = mk(1, 0, 0, 248, 8, 0, 0, 8);   // full
        vecs[9]  = mk(1, 0, 0, 247, 8, 1, 0, 8);   // push while full
        vecs[10] = mk(0, 0, 0, 248, 8, 1, 0, 8);
        vecs[11] = mk(1, 0, 1, 247, 8, 1, 0, 8);   // new error beats clear
        vecs[12] = mk(0, 0, 1, 248, 8, 0, 0, 8);   // clear; hwm takes level 8
        vecs[13] = mk(0, 1, 0, 248, 7, 0, 0, 8);
        vecs[14] = mk(0, 1, 0, 249, 6, 0, 0, 8);
        vecs[15] = mk(0, 1, 0, 250, 5, 0, 0, 8);
        vecs[16] = mk(0, 1, 0, 251, 4, 0, 0, 8);
        vecs[17] = mk(0, 1, 0, 252, 3, 0, 0, 8);
        vecs[18] = mk(0, 1, 0, 253, 2, 0, 0, 8);
        vecs[19] = mk(1, 1, 0, 254, 2, 0, 0, 8);   // replace top
        vecs[20] = mk(0, 1, 0, 254, 1, 0, 0, 8);
        vecs[21] = mk(0, 1, 0, 255, 0, 0, 0, 8);   // empty again
        vecs[22] = mk(0, 1, 0,   0, 0, 0, 1, 8);   // pop while empty
        vecs[23] = mk(1, 1, 0, 255, 1, 0, 1, 8);   // push&pop on empty = push
        vecs[24] = mk(0, 0, 1, 255, 1, 0, 0, 1);   // clear, hwm restarts at 1
        vecs[25] = mk(0, 1, 0, 255, 0, 0, 0, 1);
        vecs[26] = mk(0, 1, 1,   0, 0, 0, 1, 0);   // underflow beats clear
        vecs[27] = mk(1, 0, 0, 255, 1, 0, 1, 1);
        vecs[28] = mk(1, 1, 1, 255, 1, 0, 0, 1);   // replace + clear

        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
`ifdef STACK_CTRL_LOAD_EN
        sp_load = 1'b0;
        sp_din  = 8'd0;
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Reset state
        e = mk(0, 0, 0, 0, 0, 0, 0, 0).st;
        check_state("reset", e);
        check("reset addr", int'(addr), 0);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            push    = vecs[i].push;
            pop     = vecs[i].pop;
            err_clr = vecs[i].clr;
            #3;
            check($sformatf("v%0d addr", i), int'(addr), int'(vecs[i].addr));
            sb.push_back(vecs[i].st);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check($sformatf("v%0d scoreboard empty", i), 0, 1);
            end else begin
                got_exp = sb.pop_front();
                check_state($sformatf("v%0d", i), got_exp);
            end
        end
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
        check("scoreboard drained", sb.size(), 0);

        // Asynchronous reset in the middle of a push cycle (level is 1 here).
        push = 1'b1;
        #3 rst = 1'b1;
        #1;
        check("rst mid-push level", int'(level), 0);
        check("rst mid-push empty", int'(empty), 1);
        check("rst mid-push udf", int'(udf_err), 0);
        check("rst mid-push hwm", int'(hwm), 0);
        check("rst mid-push addr", int'(addr), 255);
        @(posedge clk);
        #2;
        rst  = 1'b0;
        push = 1'b0;
        #1;
        check("post-rst idle addr", int'(addr), 0);
        check("post-rst level", int'(level), 0);

`ifdef STACK_CTRL_LOAD_EN
        // Restore sp to 250: five entries on the stack.
        @(posedge clk);
        #1;
        sp_load = 1'b1;
        sp_din  = 8'd250;
        @(posedge clk);
        #1;
        sp_load = 1'b0;
        #1;
        check("load250 level", int'(level), 5);
        check("load250 hwm", int'(hwm), 5);
        check("load250 ovf", int'(ovf_err), 0);
        check("load250 addr", int'(addr), 251);

        // Out-of-window value is rejected and flags overflow.
        sp_load = 1'b1;
        sp_din  = 8'd100;
        @(posedge clk);
        #1;
        sp_load = 1'b0;
        #1;
        check("load100 level", int'(level), 5);
        check("load100 ovf", int'(ovf_err), 1);
        check("load100 addr", int'(addr), 251);

        // Lowest legal value LIMIT-1 fills the stack; load beats a pop.
        sp_load = 1'b1;
        sp_din  = 8'd247;
        pop     = 1'b1;
        @(posedge clk);
        #1;
        sp_load = 1'b0;
        pop     = 1'b0;
        #1;
        check("load247 level", int'(level), 8);
        check("load247 full", int'(full), 1);
        check("load247 hwm", int'(hwm), 8);

        // Rst mid-push after a load returns sp to BASE.
        push = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("load rst addr", int'(addr), 255);
        check("load rst level", int'(level), 0);
        check("load rst ovf", int'(ovf_err), 0);
        @(posedge clk);
        #2;
        rst  = 1'b0;
        push = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
